// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the multi-cycle adder/subtractor:
//     - state_e      : sequencing FSM states (idle, running, result-valid pulse)
//     - num_chunks() : number of CHUNK-wide slices in a WIDTH-bit operand
//     - idx_width()  : width of the chunk index counter (never below 1 bit)
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter so that the
  // index register and its comparisons keep a legal, non-zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
//   Combinational CHUNK-bit ripple-carry adder made of full_adder cells.
//   Parameters:
//     CHUNK : slice width in bits (>= 1)
//   Ports:
//     in1, in2 : CHUNK-bit operand slices
//     cin      : carry into bit 0
//     sum      : CHUNK-bit result slice
//     cout     : carry out of the top bit
//     c_msb    : carry into the top bit (used for signed overflow detection
//                when this slice holds the operand MSB)
// -----------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] in1,
  input  logic [CHUNK-1:0] in2,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // c[i] is the carry into bit i; c[CHUNK] leaves the slice.
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a_i (in1[i]),
      .b_i (in2[i]),
      .c_i (c[i]),
      .s_o (sum[i]),
      .c_o (c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit combinational full adder, the building block of chunk_adder.
//   Ports:
//     a_i, b_i : operand bits
//     c_i      : carry in
//     s_o      : sum bit
//     c_o      : carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//   WIDTH-bit adder/subtractor that processes CHUNK bits per clock using one
//   shared chunk_adder, with the carry registered between slices. An accepted
//   start captures the operands; the result appears N = WIDTH/CHUNK clocks
//   later together with a one-cycle done pulse. CHUNK=1 is bit-serial,
//   CHUNK=WIDTH is a single-cycle registered adder.
//   Parameters:
//     WIDTH : operand/result width (>= 2)
//     CHUNK : bits per clock, must divide WIDTH
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset
//     start : request, accepted only while not busy
//     sub   : 0 = in1+in2+cin, 1 = in1-in2-cin
//     in1   : operand A
//     in2   : operand B
//     cin   : carry-in (add) / borrow-in (sub)
//     busy  : operation in progress
//     done  : one-cycle pulse, sum/cout/ovf valid
//     sum   : result, held from done until the next accepted start
//     cout  : raw carry out of the MSB (sub: 1 = no borrow)
//     ovf   : two's-complement signed overflow
// -----------------------------------------------------------------------------
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if (WIDTH < 2) begin : g_chk_width
    $error("multicycle_adder: WIDTH must be >= 2");
  end
  if ((WIDTH % CHUNK) != 0) begin : g_chk_chunk
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             c_msb;
  logic             load;

  // Slice selection by index; the counter always points at the slice being
  // added in the current RUN cycle.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .in1   (a_chunk),
    .in2   (b_chunk),
    .cin   (carry_q),
    .sum   (s_chunk),
    .cout  (c_chunk),
    .c_msb (c_msb)
  );

  // A new request is taken when idle, and also in the done cycle so that
  // back-to-back operations run without a bubble.
  assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end

      S_RUN: begin
        // Partial sums overwrite the previous result slice by slice.
        for (int k = 0; k < N; k++) begin
          if (idx_q == IW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = c_chunk;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = c_chunk;
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d   = c_msb ^ c_chunk;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Subtraction is in1 + ~in2 + ~cin, so B and the carry are inverted once
    // at capture and the slice datapath is always a plain add.
    if (load) begin
      a_d     = in1;
      b_d     = in2 ^ {WIDTH{sub}};
      carry_d = cin ^ sub;
      idx_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//   Bench for multicycle_adder: a 32/8 instance driven from a vector table,
//   hand-written handshake/reset sequences and random operands, plus three
//   8-bit instances (CHUNK 8, 4, 1) driven in parallel over a corner/random
//   grid. Expected results come from an arithmetic model of add/sub.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, sub, cin;
  logic [31:0] in1, in2;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic        start8, sub8, cin8;
  logic [7:0]  in8a, in8b;
  logic        busy8 [3];
  logic        done8 [3];
  logic [7:0]  sum8  [3];
  logic        cout8 [3];
  logic        ovf8  [3];

  localparam int LAT8 [3] = '{1, 2, 8};

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .in1(in1), .in2(in2),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut8_c8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .in1(in8a), .in2(in8b),
    .cin(cin8), .busy(busy8[0]), .done(done8[0]), .sum(sum8[0]),
    .cout(cout8[0]), .ovf(ovf8[0])
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(4)) dut8_c4 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .in1(in8a), .in2(in8b),
    .cin(cin8), .busy(busy8[1]), .done(done8[1]), .sum(sum8[1]),
    .cout(cout8[1]), .ovf(ovf8[1])
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(1)) dut8_c1 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .in1(in8a), .in2(in8b),
    .cin(cin8), .busy(busy8[2]), .done(done8[2]), .sum(sum8[2]),
    .cout(cout8[2]), .ovf(ovf8[2])
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        s;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t tbl [8];

  // Reference: exact integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    longint m, ua, ub, sa, sb, ci, r, sr;
    res_t   res;
    m  = longint'(1) << w;
    ua = {32'h0, a} & (m - 1);
    ub = {32'h0, b} & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ci = c ? longint'(1) : longint'(0);
    if (!s) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
    end
    res.sum  = 32'(r & (m - 1));
    res.cout = s ? (r >= 0) : (r >= m);
    res.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
    return res;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    @(negedge clk);
    in1 = a; in2 = b; cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns edges until done and the
  // number of samples with busy high.
  task automatic wait_done32(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic op32(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic s,
                      input logic [31:0] es, input logic ec, input logic eo);
    int lat, bc;
    start32(a, b, c, s);
    wait_done32(lat, bc);
    chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd4);
    chk({nm, " result"}, {cout, ovf, sum}, {ec, eo, es});
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    int   lat [3];
    int   cyc;
    res_t m;
    @(negedge clk);
    in8a = a; in8b = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    chk("busy8 after start", {busy8[0], busy8[1], busy8[2]}, 3'b111);
    lat = '{0, 0, 0};
    cyc = 0;
    while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && cyc < 16) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) if (done8[d] && lat[d] == 0) lat[d] = cyc;
    end
    m = model(8, {24'h0, a}, {24'h0, b}, c, s);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("lat8[%0d] %02h %02h c%0d s%0d", d, a, b, c, s), 64'(lat[d]), 64'(LAT8[d]));
      chk($sformatf("res8[%0d] %02h %02h c%0d s%0d", d, a, b, c, s),
          {cout8[d], ovf8[d], sum8[d]}, {m.cout, m.ovf, m.sum[7:0]});
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, bc, seen;
    res_t m;
    logic [7:0] gv [16];
    logic [31:0] ra, rb;
    logic        rc, rs;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; in8a = '0; in8b = '0;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tbl[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset state 32", {busy, done, cout, ovf, sum}, 36'h0);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset state 8[%0d]", d), {busy8[d], done8[d], cout8[d], ovf8[d], sum8[d]}, 12'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op32($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s,
           tbl[i].es, tbl[i].ec, tbl[i].eo);

    // Start while busy is ignored; start in the done cycle is accepted.
    start32(32'h00000003, 32'h00000004, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    in1 = 32'hDEADBEEF; in2 = 32'h11111111; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done32(lat, bc);
    chk("ignored start: done edge", 64'(lat), 64'd1);
    chk("ignored start: result", {cout, ovf, sum}, {1'b0, 1'b0, 32'h00000007});
    start32(32'h00001000, 32'h00000001, 1'b0, 1'b1);
    chk("back-to-back: busy/done", {busy, done}, 2'b10);
    wait_done32(lat, bc);
    chk("back-to-back: latency", 64'(lat), 64'd4);
    chk("back-to-back: busy_cycles", 64'(bc), 64'd4);
    chk("back-to-back: result", {cout, ovf, sum}, {1'b1, 1'b0, 32'h00000FFF});

    // Asynchronous reset after two chunks discards the operation.
    start32(32'hAAAA0000, 32'h5555FFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async reset mid-op", {busy, done, cout, ovf, sum}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("no activity after reset", 64'(seen), 64'd0);
    op32("post-reset op", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if (i < 20) begin
        ra = {ra[31], {31{ra[30]}}};
        rb = {rb[31], {31{rb[30]}}};
      end
      m = model(32, ra, rb, rc, rs);
      op32($sformatf("rnd32 %08h %08h c%0d s%0d", ra, rb, rc, rs), ra, rb, rc, rs, m.sum, m.cout, m.ovf);
    end

    gv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h7E, 8'h81, 8'hFE,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 8; i < 16; i++) gv[i] = 8'($urandom);
    for (int cs = 0; cs < 4; cs++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          op8(gv[i], gv[j], cs[0], cs[1]);

    for (int i = 0; i < 200; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
